// File: rtl/icache_refill_if.sv
// Bus bundle between the IF stage, the instruction cache and the instruction RAM port.
// The cache is the slave; the master side drives requests and returns RAM read data.
interface icache_refill_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              cpu_rd_req;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              flush;
    logic [ADDR_W-1:0] mem_addra;
    logic [31:0]       mem_douta;

    modport slave (
        input  cpu_rd_req,
        input  cpu_addr,
        input  flush,
        input  mem_douta,
        output cpu_rdata,
        output cpu_stall,
        output mem_addra
    );

    modport master (
        output cpu_rd_req,
        output cpu_addr,
        output flush,
        output mem_douta,
        input  cpu_rdata,
        input  cpu_stall,
        input  mem_addra
    );
endinterface

// File: rtl/icache_refill.sv
// Direct-mapped read-only instruction cache with word-by-word line refill from a
// 1-cycle-latency instruction RAM, plus hit/miss counters.
module icache_refill #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned INDEX_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    icache_refill_if.slave bus,
    output logic [31:0]    hit_cnt,
    output logic [31:0]    miss_cnt
);
    localparam int unsigned LINE_WORDS = 1 << OFFSET_W;
    localparam int unsigned SETS       = 1 << INDEX_W;
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;

    localparam logic [OFFSET_W:0]   CNT_LAST = (OFFSET_W + 1)'(LINE_WORDS);
    localparam logic [OFFSET_W-1:0] OFF_LAST = OFFSET_W'(LINE_WORDS - 1);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e              state_q;
    logic [OFFSET_W:0]   cnt_q;
    logic [ADDR_W-1:0]   miss_base_q;
    logic [ADDR_W-1:0]   mem_addra_q;
    logic [SETS-1:0]     valid_q;
    logic                pending_flush_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [31:0]         data_q [SETS][LINE_WORDS];

    logic [ADDR_W-1:0]   word_addr;
    logic [OFFSET_W-1:0] req_off;
    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [ADDR_W-1:0]   line_base;
    logic                hit;
    logic                miss;
    logic [INDEX_W-1:0]  fill_idx;
    logic [OFFSET_W-1:0] fill_off;
    logic                fill_wr;
    logic                fill_done;
    logic [OFFSET_W:0]   cnt_inc;
    logic [OFFSET_W-1:0] next_fill_off;
    logic [ADDR_W-1:0]   next_fill_addr;
    logic                unused_addr_bits;

    // Address decode of the current fetch
    always_comb begin
        word_addr = bus.cpu_addr[ADDR_W+1:2];
        req_off   = word_addr[OFFSET_W-1:0];
        req_idx   = word_addr[OFFSET_W +: INDEX_W];
        req_tag   = word_addr[ADDR_W-1 -: TAG_W];
        line_base = {req_tag, req_idx, {OFFSET_W{1'b0}}};
    end

    assign unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0]};

    always_comb begin
        hit  = (state_q == StIdle) && bus.cpu_rd_req && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);
        miss = (state_q == StIdle) && bus.cpu_rd_req && !hit;
    end

    always_comb begin
        bus.cpu_rdata = hit ? data_q[req_idx][req_off] : 32'h0;
        bus.cpu_stall = miss || (state_q == StFill);
        bus.mem_addra = mem_addra_q;
    end

    // Refill bookkeeping; RAM data seen at cnt belongs to the address issued at cnt-1
    always_comb begin
        fill_idx       = miss_base_q[OFFSET_W +: INDEX_W];
        fill_off       = OFFSET_W'(cnt_q - 1'b1);
        fill_wr        = (state_q == StFill) && (cnt_q != '0);
        fill_done      = (state_q == StFill) && (cnt_q == CNT_LAST);
        cnt_inc        = cnt_q + 1'b1;
        next_fill_off  = (cnt_inc >= CNT_LAST) ? OFF_LAST : cnt_inc[OFFSET_W-1:0];
        next_fill_addr = {miss_base_q[ADDR_W-1:OFFSET_W], next_fill_off};
    end

    // Line storage is not reset; valid bits alone guard it
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            data_q[fill_idx][fill_off] <= bus.mem_douta;
        end
        if (fill_done) begin
            tag_q[fill_idx] <= miss_base_q[ADDR_W-1 -: TAG_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            miss_base_q     <= '0;
            mem_addra_q     <= '0;
            valid_q         <= '0;
            pending_flush_q <= 1'b0;
            hit_cnt         <= 32'h0;
            miss_cnt        <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (hit) begin
                        hit_cnt <= hit_cnt + 32'h1;
                    end
                    if (miss) begin
                        miss_base_q      <= line_base;
                        miss_cnt         <= miss_cnt + 32'h1;
                        cnt_q            <= '0;
                        valid_q[req_idx] <= 1'b0;
                        mem_addra_q      <= line_base;
                        state_q          <= StFill;
                    end else begin
                        mem_addra_q <= word_addr;
                    end
                    if (bus.flush) begin
                        valid_q <= '0;
                    end
                end
                StFill: begin
                    if (bus.flush) begin
                        pending_flush_q <= 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        // A flush seen at any point of the refill also kills the new line
                        if (pending_flush_q || bus.flush) begin
                            valid_q <= '0;
                        end else begin
                            valid_q[fill_idx] <= 1'b1;
                        end
                        pending_flush_q <= 1'b0;
                        mem_addra_q     <= word_addr;
                        state_q         <= StIdle;
                    end else begin
                        cnt_q       <= cnt_inc;
                        mem_addra_q <= next_fill_addr;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule
